// File: rtl/eth_tx_scheduler.sv
// Round-robin frame scheduler in front of an Ethernet framer: arbitrates requesters,
// screens payload lengths, launches frames, supervises completion and times the inter-frame gap.
module eth_tx_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int IFG_CYCLES = 12,
    parameter int MAX_LEN    = 1500,
    parameter int TIMEOUT    = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*11-1:0] req_len,
    output logic [NUM_REQ-1:0]    grant,
    output logic [NUM_REQ-1:0]    reject,
    output logic                  tx_start,
    output logic [10:0]           tx_len,
    output logic [2:0]            tx_sel,
    input  logic                  tx_busy,
    input  logic                  tx_done,
    output logic                  ifg_active,
    output logic                  err_timeout
);
    typedef enum logic [1:0] {IDLE = 2'd0, LAUNCH = 2'd1, BUSY = 2'd2, GAP = 2'd3} state_t;

    localparam logic [NUM_REQ-1:0] ONE_HOT0  = {{(NUM_REQ-1){1'b0}}, 1'b1};
    localparam logic [12:0]        TMO_LAST  = 13'(TIMEOUT - 1);
    localparam logic [12:0]        IFG_LAST  = 13'(IFG_CYCLES - 1);
    localparam logic [10:0]        MAX_LEN_L = 11'(MAX_LEN);
    localparam logic [2:0]         PTR_RST   = 3'(NUM_REQ - 1);

    state_t               state_r, state_nxt_s;
    logic [2:0]           last_ptr_r, last_ptr_nxt_s;
    logic [12:0]          cnt_r, cnt_nxt_s;
    logic [NUM_REQ-1:0]   grant_r, grant_nxt_s, reject_r, reject_nxt_s;
    logic                 tx_start_r, tx_start_nxt_s;
    logic [10:0]          tx_len_r, tx_len_nxt_s;
    logic [2:0]           tx_sel_r, tx_sel_nxt_s;
    logic                 ifg_active_r, ifg_active_nxt_s;
    logic                 err_timeout_r, err_timeout_nxt_s;

    logic                 win_found_s;
    logic [2:0]           win_idx_s;
    logic [10:0]          win_len_s;
    logic                 len_ok_s;
    logic [NUM_REQ-1:0]   win_onehot_s;

    // Round-robin search starting just above the previous winner, wrapping.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = 3'd0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!win_found_s && req_valid[(int'(last_ptr_r) + k) % NUM_REQ]) begin
                win_found_s = 1'b1;
                win_idx_s   = 3'((int'(last_ptr_r) + k) % NUM_REQ);
            end else begin
                win_found_s = win_found_s;
            end
        end
        win_len_s    = req_len[int'(win_idx_s)*11 +: 11];
        len_ok_s     = (win_len_s != 11'd0) && (win_len_s <= MAX_LEN_L);
        win_onehot_s = ONE_HOT0 << win_idx_s;
    end

    // Next-state and next-output logic; every output is registered.
    always_comb begin
        state_nxt_s       = state_r;
        last_ptr_nxt_s    = last_ptr_r;
        cnt_nxt_s         = cnt_r;
        grant_nxt_s       = grant_r;
        reject_nxt_s      = '0;
        tx_start_nxt_s    = 1'b0;
        tx_len_nxt_s      = tx_len_r;
        tx_sel_nxt_s      = tx_sel_r;
        ifg_active_nxt_s  = ifg_active_r;
        err_timeout_nxt_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (win_found_s) begin
                    last_ptr_nxt_s = win_idx_s;
                    if (len_ok_s) begin
                        grant_nxt_s  = win_onehot_s;
                        tx_sel_nxt_s = win_idx_s;
                        tx_len_nxt_s = win_len_s;
                        state_nxt_s  = LAUNCH;
                    end else begin
                        reject_nxt_s = win_onehot_s;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LAUNCH: begin
                if (!tx_busy) begin
                    tx_start_nxt_s = 1'b1;
                    cnt_nxt_s      = 13'd0;
                    state_nxt_s    = BUSY;
                end else begin
                    state_nxt_s = LAUNCH;
                end
            end
            BUSY: begin
                // A done arriving on the timeout cycle wins over the abort.
                if (tx_done || (cnt_r == TMO_LAST)) begin
                    err_timeout_nxt_s = !tx_done;
                    grant_nxt_s       = '0;
                    tx_sel_nxt_s      = 3'd0;
                    tx_len_nxt_s      = 11'd0;
                    ifg_active_nxt_s  = 1'b1;
                    cnt_nxt_s         = 13'd0;
                    state_nxt_s       = GAP;
                end else begin
                    cnt_nxt_s = cnt_r + 13'd1;
                end
            end
            GAP: begin
                if (cnt_r == IFG_LAST) begin
                    ifg_active_nxt_s = 1'b0;
                    cnt_nxt_s        = 13'd0;
                    state_nxt_s      = IDLE;
                end else begin
                    cnt_nxt_s = cnt_r + 13'd1;
                end
            end
            default: begin
                grant_nxt_s      = '0;
                tx_sel_nxt_s     = 3'd0;
                tx_len_nxt_s     = 11'd0;
                ifg_active_nxt_s = 1'b0;
                cnt_nxt_s        = 13'd0;
                state_nxt_s      = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_ptr_r    <= PTR_RST;
            cnt_r         <= 13'd0;
            grant_r       <= '0;
            reject_r      <= '0;
            tx_start_r    <= 1'b0;
            tx_len_r      <= 11'd0;
            tx_sel_r      <= 3'd0;
            ifg_active_r  <= 1'b0;
            err_timeout_r <= 1'b0;
        end else begin
            last_ptr_r    <= last_ptr_nxt_s;
            cnt_r         <= cnt_nxt_s;
            grant_r       <= grant_nxt_s;
            reject_r      <= reject_nxt_s;
            tx_start_r    <= tx_start_nxt_s;
            tx_len_r      <= tx_len_nxt_s;
            tx_sel_r      <= tx_sel_nxt_s;
            ifg_active_r  <= ifg_active_nxt_s;
            err_timeout_r <= err_timeout_nxt_s;
        end
    end

    assign grant       = grant_r;
    assign reject      = reject_r;
    assign tx_start    = tx_start_r;
    assign tx_len      = tx_len_r;
    assign tx_sel      = tx_sel_r;
    assign ifg_active  = ifg_active_r;
    assign err_timeout = err_timeout_r;

endmodule

// File: tb/tb_eth_tx_scheduler.sv
// Scoreboard bench for eth_tx_scheduler: directed stimulus pushes expected events with
// their cycle numbers; a negedge monitor pops and compares whenever the DUT emits one.
module tb_eth_tx_scheduler;
    localparam int NREQ = 4;
    localparam int IFG  = 12;
    localparam int TMO  = 4096;

    localparam int K_GRANT = 0;
    localparam int K_START = 1;
    localparam int K_GAP   = 2;
    localparam int K_REJ   = 3;
    localparam int K_TMO   = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*11-1:0] req_len = '0;
    logic [NREQ-1:0]   grant, reject;
    logic              tx_start;
    logic [10:0]       tx_len;
    logic [2:0]        tx_sel;
    logic              tx_busy = 1'b0;
    logic              tx_done = 1'b0;
    logic              ifg_active, err_timeout;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    logic finish_req = 1'b0;

    int          q_kind[$];
    logic [31:0] q_data[$];
    int          q_cyc[$];

    eth_tx_scheduler #(.NUM_REQ(NREQ), .IFG_CYCLES(IFG), .MAX_LEN(1500), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_len(req_len),
        .grant(grant), .reject(reject), .tx_start(tx_start), .tx_len(tx_len),
        .tx_sel(tx_sel), .tx_busy(tx_busy), .tx_done(tx_done),
        .ifg_active(ifg_active), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic string kname(input int k);
        case (k)
            K_GRANT: return "grant";
            K_START: return "tx_start";
            K_GAP:   return "ifg_len";
            K_REJ:   return "reject";
            K_TMO:   return "err_timeout";
            default: return "unknown";
        endcase
    endfunction

    function automatic logic [31:0] pack_g(input logic [3:0] g, input logic [2:0] s, input logic [10:0] l);
        return {14'd0, g, s, l};
    endfunction

    task automatic push(input int k, input logic [31:0] d, input int c);
        q_kind.push_back(k);
        q_data.push_back(d);
        q_cyc.push_back(c);
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_done(input int c);
        goto(c);
        tx_done = 1'b1;
        goto(c + 1);
        tx_done = 1'b0;
    endtask

    // Expect grant at g_cyc, start one cycle later, tx_done 'busy' cycles after start, then the gap.
    task automatic do_frame(input int g_cyc, input logic [3:0] g, input logic [2:0] s,
                            input logic [10:0] l, input int busy, input bit drop, output int next_g);
        int st, d;
        st = g_cyc + 1;
        d  = st + busy;
        push(K_GRANT, pack_g(g, s, l), g_cyc);
        push(K_START, {28'd0, g}, st);
        push(K_GAP, 32'(IFG), d + IFG + 1);
        if (drop) begin
            goto(g_cyc);
            req_valid = '0;
        end
        pulse_done(d);
        next_g = d + IFG + 2;
    endtask

    task automatic check_ev(input int k, input logic [31:0] d);
        checks++;
        if (q_kind.size() == 0) begin
            failures++;
            $display("FAIL unexpected_%s got data=%h cyc=%0d required no event", kname(k), d, cyc);
        end else begin
            int ek, ec;
            logic [31:0] ed;
            ek = q_kind.pop_front();
            ed = q_data.pop_front();
            ec = q_cyc.pop_front();
            if (ek != k || ed != d || ec != cyc) begin
                failures++;
                $display("FAIL ev_%s got %s data=%h cyc=%0d required %s data=%h cyc=%0d",
                         kname(ek), kname(k), d, cyc, kname(ek), ed, ec);
            end
        end
    endtask

    logic [NREQ-1:0] prev_grant = '0;
    logic [31:0]     held = '0;
    logic            ifg_prev = 1'b0;
    logic            rst_prev = 1'b0;
    int              ifg_rise = 0;

    // Monitor: pops the scoreboard on every DUT event and checks invariants.
    always @(negedge clk) begin
        if (rst) begin
            if (rst_prev) begin
                checks++;
                if ({grant, reject, tx_start, tx_len, tx_sel, ifg_active, err_timeout} != '0) begin
                    failures++;
                    $display("FAIL reset_outputs got grant=%b reject=%b start=%b len=%0d sel=%0d ifg=%b tmo=%b required all 0",
                             grant, reject, tx_start, tx_len, tx_sel, ifg_active, err_timeout);
                end
            end
            prev_grant = '0;
            ifg_prev   = 1'b0;
        end else begin
            checks++;
            if ((grant != '0 && reject != '0) || !$onehot0(grant) || !$onehot0(reject)) begin
                failures++;
                $display("FAIL exclusive got grant=%b reject=%b required one-hot, not both", grant, reject);
            end
            if (reject != '0) check_ev(K_REJ, {28'd0, reject});
            if (grant != '0 && prev_grant == '0) begin
                check_ev(K_GRANT, pack_g(grant, tx_sel, tx_len));
                held = pack_g(grant, tx_sel, tx_len);
            end else if (grant != '0) begin
                checks++;
                if (pack_g(grant, tx_sel, tx_len) != held) begin
                    failures++;
                    $display("FAIL grant_hold got %h required %h", pack_g(grant, tx_sel, tx_len), held);
                end
            end
            if (tx_start) check_ev(K_START, {28'd0, grant});
            if (err_timeout) check_ev(K_TMO, 32'd0);
            if (ifg_active && !ifg_prev) begin
                ifg_rise = cyc;
                checks++;
                if (pack_g(grant, tx_sel, tx_len) != 32'd0) begin
                    failures++;
                    $display("FAIL gap_clear got %h required 0", pack_g(grant, tx_sel, tx_len));
                end
            end
            if (!ifg_active && ifg_prev) check_ev(K_GAP, 32'(cyc - ifg_rise));
            prev_grant = grant;
            ifg_prev   = ifg_active;
        end
        rst_prev = rst;
        if (finish_req) begin
            checks++;
            if (q_kind.size() != 0) begin
                failures++;
                $display("FAIL leftover got %0d pending events required 0 (next %s at cyc %0d)",
                         q_kind.size(), kname(q_kind[0]), q_cyc[0]);
            end
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    // Directed stimulus.
    initial begin
        int n, nx, s;
        goto(3);
        rst = 1'b0;

        // Basic launch, gap length, then round-robin to requester 2.
        n = cyc + 2;
        goto(n);
        req_valid = 4'b0101;
        req_len[0 +: 11]  = 11'd64;
        req_len[22 +: 11] = 11'd200;
        do_frame(n + 1, 4'b0001, 3'd0, 11'd64, 5, 1'b0, nx);
        do_frame(nx, 4'b0100, 3'd2, 11'd200, 3, 1'b1, nx);
        goto(nx + 1);

        // Fairness with all requesters valid, starting fresh from reset.
        rst = 1'b1;
        goto(cyc + 3);
        rst = 1'b0;
        n = cyc + 1;
        goto(n);
        req_valid = 4'b1111;
        for (int i = 0; i < NREQ; i++) req_len[i*11 +: 11] = 11'd100;
        nx = n + 1;
        for (int i = 0; i < 5; i++) begin
            do_frame(nx, 4'(1 << (i % 4)), 3'(i % 4), 11'd100, 50, i == 4, nx);
        end
        goto(nx);

        // Length screening: 0 and 1501 rejected, 1500 accepted.
        n = cyc + 2;
        goto(n);
        req_valid = 4'b0010;
        req_len[11 +: 11] = 11'd0;
        push(K_REJ, 32'h2, n + 1);
        goto(n + 1);
        req_valid = '0;
        goto(n + 3);
        req_valid = 4'b0010;
        req_len[11 +: 11] = 11'd1501;
        push(K_REJ, 32'h2, n + 4);
        goto(n + 4);
        req_valid = '0;
        goto(n + 6);
        req_valid = 4'b0010;
        req_len[11 +: 11] = 11'd1500;
        do_frame(n + 7, 4'b0010, 3'd1, 11'd1500, 2, 1'b1, nx);
        goto(nx);

        // Framer busy for 20 cycles after grant holds back tx_start.
        n = cyc + 2;
        goto(n);
        req_valid = 4'b1000;
        req_len[33 +: 11] = 11'd300;
        tx_busy = 1'b1;
        push(K_GRANT, pack_g(4'b1000, 3'd3, 11'd300), n + 1);
        push(K_START, 32'h8, n + 22);
        push(K_GAP, 32'(IFG), n + 26 + IFG + 1);
        goto(n + 1);
        req_valid = '0;
        goto(n + 21);
        tx_busy = 1'b0;
        pulse_done(n + 26);
        goto(n + 26 + IFG + 3);

        // Stray done while idle, then a timeout, then done exactly on the timeout cycle.
        pulse_done(cyc + 1);
        n = cyc + 2;
        goto(n);
        req_valid = 4'b0011;
        req_len[0 +: 11]  = 11'd80;
        req_len[11 +: 11] = 11'd90;
        s = n + 2;
        push(K_GRANT, pack_g(4'b0001, 3'd0, 11'd80), n + 1);
        push(K_START, 32'h1, s);
        push(K_TMO, 32'd0, s + TMO);
        push(K_GAP, 32'(IFG), s + TMO + IFG);
        do_frame(s + TMO + IFG + 1, 4'b0010, 3'd1, 11'd90, TMO - 1, 1'b1, nx);
        goto(nx);

        // Reset in the middle of a frame, then a fresh grant.
        n = cyc + 2;
        goto(n);
        req_valid = 4'b0100;
        req_len[22 +: 11] = 11'd60;
        push(K_GRANT, pack_g(4'b0100, 3'd2, 11'd60), n + 1);
        push(K_START, 32'h4, n + 2);
        goto(n + 1);
        req_valid = '0;
        goto(n + 5);
        rst = 1'b1;
        goto(n + 7);
        rst = 1'b0;
        req_valid = 4'b0100;
        req_len[22 +: 11] = 11'd61;
        do_frame(n + 8, 4'b0100, 3'd2, 11'd61, 3, 1'b1, nx);
        goto(nx + 2);
        finish_req = 1'b1;
    end

endmodule

// File: doc/eth_tx_scheduler.md
ETH_TX_SCHEDULER -- requirements
Module: eth_tx_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4, number of frame requesters sharing the framing transmitter (2..8).
REQ-002 Parameter IFG_CYCLES, default 12, inter-frame gap in clk cycles (>=1).
REQ-003 Parameter MAX_LEN, default 1500, largest legal payload length in bytes.
REQ-004 Parameter TIMEOUT, default 4096, max cycles from tx_start to tx_done before abort.
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 req_valid  in  NUM_REQ  bit i high: requester i holds a complete frame.
REQ-008 req_len  in  NUM_REQ*11  requester i payload length in bytes, bits [11*i+10:11*i].
REQ-009 grant  out  NUM_REQ  one-hot; requester i owns the transmitter.
REQ-010 reject  out  NUM_REQ  one-hot single-cycle pulse; requester i must discard its frame.
REQ-011 tx_start  out  1  single-cycle pulse; framer begins a frame.
REQ-012 tx_len  out  11  payload length of the granted frame, stable while grant is nonzero.
REQ-013 tx_sel  out  3  binary index of granted requester, stable while grant is nonzero.
REQ-014 tx_busy  in  1  framer not ready to accept tx_start.
REQ-015 tx_done  in  1  single-cycle pulse after last FCS byte.
REQ-016 ifg_active  out  1  high during inter-frame gap.
REQ-017 err_timeout  out  1  single-cycle pulse on abort by timeout.

Function
REQ-018 FSM states IDLE, LAUNCH, BUSY, GAP; one state register, next state registered.
REQ-019 IDLE: if any req_valid bit is high, select winner by round-robin, searching upward from (last_ptr+1) mod NUM_REQ, wrapping.
REQ-020 Winner with req_len==0 or req_len>MAX_LEN: reject[i] pulses next cycle, last_ptr<=i, FSM stays IDLE; no grant, no tx_start.
REQ-021 Legal winner: next cycle grant[i]=1, tx_sel=i, tx_len=req_len latched, last_ptr<=i, FSM->LAUNCH.
REQ-022 LAUNCH: when tx_busy==0, tx_start pulses one cycle and FSM->BUSY; while tx_busy==1, hold in LAUNCH, tx_start low.
REQ-023 Latency: req_valid seen in IDLE with tx_busy low -> grant at +1 cycle, tx_start at +2 cycles.
REQ-024 BUSY: 13-bit cycle counter from 0 after tx_start; tx_done ->GAP; counter reaching TIMEOUT-1 without tx_done -> err_timeout pulse, ->GAP.
REQ-025 tx_done outside BUSY is ignored; tx_done in the cycle of timeout counts as done, no err_timeout.
REQ-026 GAP: grant, tx_sel, tx_len cleared on entry; ifg_active=1 for exactly IFG_CYCLES cycles, then ->IDLE.
REQ-027 req_valid sampled only in IDLE; changes to req_valid or req_len while granted have no effect on the current frame.
REQ-028 Minimum spacing between consecutive tx_start pulses: IFG_CYCLES+3 cycles plus frame time.
REQ-029 At most one of grant, reject is nonzero in any cycle; both one-hot or zero.
REQ-030 Fairness: with all requesters continuously valid and legal, grants rotate 0,1,...,NUM_REQ-1,0.

Reset
REQ-031 While rst high: FSM=IDLE, last_ptr=NUM_REQ-1 (requester 0 first), counters 0.
REQ-032 Reset values: grant=0, reject=0, tx_start=0, tx_len=0, tx_sel=0, ifg_active=0, err_timeout=0.
REQ-033 rst in any state, including mid-frame or mid-gap, aborts without err_timeout; first grant after release follows REQ-019.

Verification
REQ-034 After reset, req_valid=4'b0101, req_len[0]=64, tx_busy=0 -> grant=0001 at +1, tx_start at +2, tx_len=64; tx_done -> ifg_active high 12 cycles; next grant=0100.
REQ-035 req_valid=4'b1111 held, all len=100, tx_done 50 cycles after each tx_start -> grant order 0,1,2,3,0; spacing per REQ-028.
REQ-036 req_valid=4'b0010, req_len[1]=0 -> reject=0010 one cycle, no tx_start; then req_len[1]=1501 -> reject again; len=1500 -> granted.
REQ-037 tx_busy=1 for 20 cycles after grant -> tx_start withheld, fires cycle after tx_busy falls; grant held throughout.
REQ-038 tx_done never arrives -> err_timeout at 4096 cycles after tx_start, GAP entered, then next requester granted.
REQ-039 rst pulsed during BUSY with grant=0100 -> all outputs 0 next cycle; after release, req_valid=4'b0100 -> grant=0100 by search from 0.
